// File: rtl/hazard_pkg.sv
// Shared types for the scoreboard hazard controller: slot entries, pipeline
// control bundle and the priority-encoded control mode.
package hazard_pkg;

  localparam int NUM_SLOTS_DEFAULT = 4;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } slot_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_exe_en;
    logic exe_mem_en;
    logic mem_wb_en;
    logic if_id_clr;
    logic id_exe_clr;
    logic exe_mem_clr;
    logic mem_wb_clr;
  } pipe_ctrl_t;

  typedef enum logic [2:0] {
    PC_TRAP,
    PC_BRANCH,
    PC_EXT_STALL,
    PC_ID_STALL,
    PC_RUN
  } pipe_mode_e;

  // Bit order is {pc, if_id, id_exe, exe_mem, mem_wb enables, then the four clears}
  localparam pipe_ctrl_t CTRL_RESET = pipe_ctrl_t'({5'b00000, 4'b1111});

  function automatic pipe_ctrl_t mode_ctrl(input pipe_mode_e mode);
    pipe_ctrl_t c;
    unique case (mode)
      PC_TRAP:      c = pipe_ctrl_t'({5'b11111, 4'b1111});
      PC_BRANCH:    c = pipe_ctrl_t'({5'b11111, 4'b1110});
      PC_EXT_STALL: c = pipe_ctrl_t'({5'b00000, 4'b0000});
      PC_ID_STALL:  c = pipe_ctrl_t'({5'b00111, 4'b0100});
      default:      c = pipe_ctrl_t'({5'b11111, 4'b0000});
    endcase
    return c;
  endfunction

  function automatic logic slot_match(input slot_t s, input logic [4:0] r);
    return s.valid && (s.rd == r) && (r != 5'd0);
  endfunction

endpackage

// File: rtl/sb_slot_table.sv
// Outstanding long-latency writeback table: allocation, completion, free-slot
// encoder, occupancy count and register match queries.
module sb_slot_table
  import hazard_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEFAULT,
  parameter int TAG_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_issue,
  input  logic [4:0]       i_issue_rd,
  output logic [TAG_W-1:0] o_free_tag,
  input  logic             i_done,
  input  logic [TAG_W-1:0] i_done_tag,
  input  logic [4:0]       i_q_rs1,
  input  logic [4:0]       i_q_rs2,
  input  logic [4:0]       i_q_rd,
  output logic             o_m_rs1,
  output logic             o_m_rs2,
  output logic             o_m_rd,
  output logic             o_full,
  output logic [TAG_W:0]   o_busy_count
);

  slot_t                r_slots [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] w_valid;
  logic [TAG_W-1:0]     w_free_tag;
  logic [TAG_W:0]       w_busy;
  logic                 w_full;
  logic                 w_done_hit;
  logic                 w_m_rs1, w_m_rs2, w_m_rd;

  always_comb begin
    w_valid    = '0;
    w_free_tag = '0;
    w_busy     = '0;
    w_done_hit = 1'b0;
    w_m_rs1    = 1'b0;
    w_m_rs2    = 1'b0;
    w_m_rd     = 1'b0;
    // Descending scan so the lowest-index free slot is the last one written
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      w_valid[i] = r_slots[i].valid;
      if (!r_slots[i].valid) w_free_tag = TAG_W'(i);
      w_busy     = w_busy + {{TAG_W{1'b0}}, r_slots[i].valid};
      w_done_hit = w_done_hit | (r_slots[i].valid && i_done_tag == TAG_W'(i));
      w_m_rs1    = w_m_rs1 | slot_match(r_slots[i], i_q_rs1);
      w_m_rs2    = w_m_rs2 | slot_match(r_slots[i], i_q_rs2);
      w_m_rd     = w_m_rd  | slot_match(r_slots[i], i_q_rd);
    end
  end

  assign w_full = &w_valid;

  // NOTE: the whole table is reset, not just valid, so rd never carries X into the match compare.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) r_slots[i] <= '{valid: 1'b0, rd: 5'd0};
    end else begin
      // NOTE: non-blocking, so a later issue to the same slot wins over the done clear in this loop.
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (i_done && i_done_tag == TAG_W'(i)) r_slots[i].valid <= 1'b0;
        if (i_issue && !w_full && w_free_tag == TAG_W'(i))
          r_slots[i] <= '{valid: 1'b1, rd: i_issue_rd};
      end
    end
  end

  a_issue_when_full: assert property (@(posedge clk) disable iff (!reset_n)
    !(i_issue && w_full));
  a_done_to_free_slot: assert property (@(posedge clk) disable iff (!reset_n)
    !(i_done && !w_done_hit));

  assign o_free_tag   = w_free_tag;
  assign o_full       = w_full;
  assign o_busy_count = w_busy;
  assign o_m_rs1      = w_m_rs1;
  assign o_m_rs2      = w_m_rs2;
  assign o_m_rd       = w_m_rd;

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// ID-stage hazard detection over the long-op scoreboard plus prioritised
// pipeline enable/clear generation and a saturating stall-cycle counter.
module hazard_scoreboard_ctrl
  import hazard_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEFAULT,
  parameter int TAG_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_long_op,
  input  logic             exe_mem_read,
  input  logic [4:0]       exe_rd,
  input  logic             lo_issue,
  input  logic [4:0]       lo_issue_rd,
  output logic [TAG_W-1:0] lo_issue_tag,
  input  logic             lo_done,
  input  logic [TAG_W-1:0] lo_done_tag,
  input  logic             pc_sel_mem,
  input  logic             trap_flush,
  input  logic             stall_pipl,
  output logic             pc_reg_en,
  output logic             if_id_reg_en,
  output logic             id_exe_reg_en,
  output logic             exe_mem_reg_en,
  output logic             mem_wb_reg_en,
  output logic             if_id_reg_clr,
  output logic             id_exe_reg_clr,
  output logic             exe_mem_reg_clr,
  output logic             mem_wb_reg_clr,
  output logic             sb_full,
  output logic [TAG_W:0]   sb_busy_count,
  output logic [CNT_W-1:0] stall_cycles
);

  logic             w_m_rs1, w_m_rs2, w_m_rd;
  logic             w_raw, w_waw, w_load, w_struct, w_id_stall;
  pipe_mode_e       w_mode;
  pipe_ctrl_t       w_ctrl;
  logic [CNT_W-1:0] r_stall_cycles;

  sb_slot_table #(.NUM_SLOTS(NUM_SLOTS), .TAG_W(TAG_W)) u_slots (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_issue      (lo_issue),
    .i_issue_rd   (lo_issue_rd),
    .o_free_tag   (lo_issue_tag),
    .i_done       (lo_done),
    .i_done_tag   (lo_done_tag),
    .i_q_rs1      (id_rs1),
    .i_q_rs2      (id_rs2),
    .i_q_rd       (id_rd),
    .o_m_rs1      (w_m_rs1),
    .o_m_rs2      (w_m_rs2),
    .o_m_rd       (w_m_rd),
    .o_full       (sb_full),
    .o_busy_count (sb_busy_count)
  );

  assign w_raw      = (id_use_rs1 && w_m_rs1) || (id_use_rs2 && w_m_rs2);
  assign w_waw      = id_reg_write && w_m_rd;
  assign w_load     = exe_mem_read && (exe_rd != 5'd0) &&
                      ((id_use_rs1 && exe_rd == id_rs1) || (id_use_rs2 && exe_rd == id_rs2));
  assign w_struct   = id_long_op && sb_full;
  assign w_id_stall = id_valid && (w_raw || w_waw || w_load || w_struct);

  // NOTE: default first so every path assigns w_mode and no latch is inferred.
  always_comb begin
    w_mode = PC_RUN;
    if (trap_flush)      w_mode = PC_TRAP;
    else if (pc_sel_mem) w_mode = PC_BRANCH;
    else if (stall_pipl) w_mode = PC_EXT_STALL;
    else if (w_id_stall) w_mode = PC_ID_STALL;
  end

  assign w_ctrl = reset_n ? mode_ctrl(w_mode) : CTRL_RESET;

  assign pc_reg_en       = w_ctrl.pc_en;
  assign if_id_reg_en    = w_ctrl.if_id_en;
  assign id_exe_reg_en   = w_ctrl.id_exe_en;
  assign exe_mem_reg_en  = w_ctrl.exe_mem_en;
  assign mem_wb_reg_en   = w_ctrl.mem_wb_en;
  assign if_id_reg_clr   = w_ctrl.if_id_clr;
  assign id_exe_reg_clr  = w_ctrl.id_exe_clr;
  assign exe_mem_reg_clr = w_ctrl.exe_mem_clr;
  assign mem_wb_reg_clr  = w_ctrl.mem_wb_clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_stall_cycles <= '0;
    else if (!w_ctrl.pc_en && r_stall_cycles != {CNT_W{1'b1}})
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed bench: each step pushes its expected control/scoreboard snapshot to a
// queue, which is popped and compared on the following falling edge.
module tb_hazard_scoreboard_ctrl;

  localparam logic [8:0] E_RUN   = {5'b11111, 4'b0000};
  localparam logic [8:0] E_IDST  = {5'b00111, 4'b0100};
  localparam logic [8:0] E_EXT   = {5'b00000, 4'b0000};
  localparam logic [8:0] E_BR    = {5'b11111, 4'b1110};
  localparam logic [8:0] E_TRAP  = {5'b11111, 4'b1111};
  localparam logic [8:0] E_RESET = {5'b00000, 4'b1111};

  logic       clk = 1'b0;
  logic       reset_n;
  logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_long_op;
  logic [4:0] id_rs1, id_rs2, id_rd, exe_rd, lo_issue_rd;
  logic       exe_mem_read, lo_issue, lo_done, pc_sel_mem, trap_flush, stall_pipl;
  logic [1:0] lo_issue_tag, lo_done_tag;
  logic       pc_reg_en, if_id_reg_en, id_exe_reg_en, exe_mem_reg_en, mem_wb_reg_en;
  logic       if_id_reg_clr, id_exe_reg_clr, exe_mem_reg_clr, mem_wb_reg_clr;
  logic       sb_full;
  logic [2:0] sb_busy_count;
  logic [3:0] stall_cycles;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [8:0] ctrl;
    logic       full;
    logic [2:0] busy;
    logic [1:0] itag;
    bit         chk_tag;
  } exp_t;

  exp_t exp_q[$];

  hazard_scoreboard_ctrl #(.NUM_SLOTS(4), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_long_op(id_long_op),
    .exe_mem_read(exe_mem_read), .exe_rd(exe_rd),
    .lo_issue(lo_issue), .lo_issue_rd(lo_issue_rd), .lo_issue_tag(lo_issue_tag),
    .lo_done(lo_done), .lo_done_tag(lo_done_tag),
    .pc_sel_mem(pc_sel_mem), .trap_flush(trap_flush), .stall_pipl(stall_pipl),
    .pc_reg_en(pc_reg_en), .if_id_reg_en(if_id_reg_en), .id_exe_reg_en(id_exe_reg_en),
    .exe_mem_reg_en(exe_mem_reg_en), .mem_wb_reg_en(mem_wb_reg_en),
    .if_id_reg_clr(if_id_reg_clr), .id_exe_reg_clr(id_exe_reg_clr),
    .exe_mem_reg_clr(exe_mem_reg_clr), .mem_wb_reg_clr(mem_wb_reg_clr),
    .sb_full(sb_full), .sb_busy_count(sb_busy_count), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [8:0] ctrl, input logic full,
                            input logic [2:0] busy, input logic [1:0] itag, input bit chk_tag);
    exp_t e;
    e.tag = tag; e.ctrl = ctrl; e.full = full; e.busy = busy;
    e.itag = itag; e.chk_tag = chk_tag;
    exp_q.push_back(e);
  endtask

  task automatic compare_now();
    exp_t e;
    logic [8:0] obs;
    checks++;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("FAIL queue_empty observed=0 expected=1");
    end
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      obs = {pc_reg_en, if_id_reg_en, id_exe_reg_en, exe_mem_reg_en, mem_wb_reg_en,
             if_id_reg_clr, id_exe_reg_clr, exe_mem_reg_clr, mem_wb_reg_clr};
      check({e.tag, "/ctrl"}, 32'(obs), 32'(e.ctrl));
      check({e.tag, "/full"}, 32'(sb_full), 32'(e.full));
      check({e.tag, "/busy"}, 32'(sb_busy_count), 32'(e.busy));
      if (e.chk_tag) check({e.tag, "/issue_tag"}, 32'(lo_issue_tag), 32'(e.itag));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_now();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_reg_write = 0; id_long_op = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; exe_mem_read = 0; exe_rd = 0;
    lo_issue = 0; lo_issue_rd = 0; lo_done = 0; lo_done_tag = 0;
    pc_sel_mem = 0; trap_flush = 0; stall_pipl = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    expect_out("reset", E_RESET, 0, 0, 0, 1);
    compare_now();
    check("reset/stall_cycles", 32'(stall_cycles), 0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    // RAW on a long op: stall through the done cycle, run the cycle after
    idle(); lo_issue = 1; lo_issue_rd = 5;
    expect_out("raw_issue", E_RUN, 0, 0, 0, 1); cycle();
    idle(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 5;
    expect_out("raw_wait1", E_IDST, 0, 1, 1, 1); cycle();
    expect_out("raw_wait2", E_IDST, 0, 1, 1, 1); cycle();
    lo_done = 1; lo_done_tag = 0;
    expect_out("raw_done_cycle", E_IDST, 0, 1, 1, 1); cycle();
    lo_done = 0;
    expect_out("raw_release", E_RUN, 0, 0, 0, 1); cycle();
    check("raw/stall_cycles", 32'(stall_cycles), 3);

    // WAW, then x0 never hazards while a same-cycle issue/done happens
    idle(); lo_issue = 1; lo_issue_rd = 9;
    expect_out("waw_issue", E_RUN, 0, 0, 0, 1); cycle();
    idle(); id_valid = 1; id_reg_write = 1; id_rd = 9;
    expect_out("waw_stall", E_IDST, 0, 1, 1, 1); cycle();
    idle(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 0;
    lo_issue = 1; lo_issue_rd = 0; lo_done = 1; lo_done_tag = 0;
    expect_out("x0_swap", E_RUN, 0, 1, 1, 1); cycle();
    idle(); id_valid = 1; id_use_rs1 = 1; id_use_rs2 = 1; id_reg_write = 1;
    expect_out("x0_read", E_RUN, 0, 1, 0, 1); cycle();
    idle(); lo_done = 1; lo_done_tag = 1;
    expect_out("x0_done", E_RUN, 0, 1, 0, 1); cycle();
    check("waw/stall_cycles", 32'(stall_cycles), 4);

    // Fill all four slots, structural stall, reuse of a freed middle slot
    for (int i = 0; i < 4; i++) begin
      idle(); lo_issue = 1; lo_issue_rd = 5'(10 + i);
      expect_out("fill", E_RUN, 0, 3'(i), 2'(i), 1); cycle();
    end
    idle(); id_valid = 1; id_long_op = 1;
    expect_out("full_struct", E_IDST, 1, 4, 0, 0); cycle();
    lo_done = 1; lo_done_tag = 2;
    expect_out("full_done2", E_IDST, 1, 4, 0, 0); cycle();
    lo_done = 0; lo_issue = 1; lo_issue_rd = 14;
    expect_out("reuse_tag2", E_RUN, 0, 3, 2, 1); cycle();
    idle(); lo_done = 1; lo_done_tag = 0;
    expect_out("refull", E_RUN, 1, 4, 0, 0); cycle();
    idle(); lo_issue = 1; lo_issue_rd = 15; lo_done = 1; lo_done_tag = 3;
    expect_out("swap_3busy", E_RUN, 0, 3, 0, 1); cycle();
    idle(); lo_done = 1; lo_done_tag = 0;
    expect_out("after_swap", E_RUN, 0, 3, 3, 1); cycle();
    lo_done_tag = 1;
    expect_out("drain1", E_RUN, 0, 2, 0, 1); cycle();
    lo_done_tag = 2;
    expect_out("drain2", E_RUN, 0, 1, 0, 1); cycle();
    idle();
    expect_out("empty", E_RUN, 0, 0, 0, 1); cycle();
    check("full/stall_cycles", 32'(stall_cycles), 6);

    // Load-use bubble and its non-hazard variants
    idle(); id_valid = 1; id_use_rs2 = 1; id_rs2 = 7; exe_mem_read = 1; exe_rd = 7;
    expect_out("load_use", E_IDST, 0, 0, 0, 1); cycle();
    exe_mem_read = 0;
    expect_out("load_bubbled", E_RUN, 0, 0, 0, 1); cycle();
    exe_mem_read = 1; exe_rd = 0; id_rs2 = 0;
    expect_out("load_x0", E_RUN, 0, 0, 0, 1); cycle();
    exe_rd = 7; id_rs2 = 7; id_use_rs2 = 0; id_use_rs1 = 1; id_rs1 = 3;
    expect_out("load_unused_rs2", E_RUN, 0, 0, 0, 1); cycle();
    id_valid = 0; id_use_rs2 = 1;
    expect_out("load_id_invalid", E_RUN, 0, 0, 0, 1); cycle();
    check("load/stall_cycles", 32'(stall_cycles), 7);

    // Priority: trap > branch > external stall > ID stall
    idle(); lo_issue = 1; lo_issue_rd = 5;
    expect_out("prio_issue", E_RUN, 0, 0, 0, 1); cycle();
    idle(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 5; stall_pipl = 1; pc_sel_mem = 1;
    expect_out("prio_branch", E_BR, 0, 1, 1, 1); cycle();
    trap_flush = 1;
    expect_out("prio_trap", E_TRAP, 0, 1, 1, 1); cycle();
    trap_flush = 0; pc_sel_mem = 0;
    expect_out("prio_ext", E_EXT, 0, 1, 1, 1); cycle();
    stall_pipl = 0;
    expect_out("prio_id", E_IDST, 0, 1, 1, 1); cycle();
    check("prio/stall_cycles", 32'(stall_cycles), 9);

    // Reset mid-stall with a busy slot
    reset_n = 1'b0;
    #1;
    expect_out("midreset", E_RESET, 0, 0, 0, 1);
    compare_now();
    check("midreset/stall_cycles", 32'(stall_cycles), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    expect_out("post_reset", E_RUN, 0, 0, 0, 1); cycle();
    check("post_reset/stall_cycles", 32'(stall_cycles), 0);

    // Counter saturation at the 4-bit ceiling
    idle(); stall_pipl = 1;
    for (int i = 0; i < 20; i++) begin
      expect_out("sat_stall", E_EXT, 0, 0, 0, 1); cycle();
    end
    check("sat/stall_cycles", 32'(stall_cycles), 15);
    idle();
    expect_out("sat_run", E_RUN, 0, 0, 0, 1); cycle();
    check("sat_hold/stall_cycles", 32'(stall_cycles), 15);

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_ctrl.md
Name: hazard_scoreboard_ctrl

Overview:
- Next-generation hazard/pipeline controller for the 5-stage RV32 core.
- Replaces single-cycle load-use detection with a parametrised scoreboard. The scoreboard tracks up to NUM_SLOTS outstanding long-latency writebacks, such as a divider or variable-latency loads, by tag.
- Detects RAW, WAW, load-use and structural hazards at ID.
- Drives all pipeline register enables/clears, with priority for trap flush, MEM-stage branch redirect and external stall. Keeps a saturating stall-cycle counter.

Parameters:
NUM_SLOTS, 4, outstanding long-latency ops tracked (1..16)
TAG_W, $clog2(NUM_SLOTS) min 1, slot tag width
CNT_W, 32, stall-cycle counter width

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs1, id_rs2  in  5 each  ID source registers
id_use_rs1, id_use_rs2  in  1 each  instruction reads rs1/rs2
id_rd  in  5  ID destination
id_reg_write  in  1  ID writes rd
id_long_op  in  1  ID instruction needs a scoreboard slot
exe_mem_read  in  1  EXE holds a load
exe_rd  in  5  EXE destination
lo_issue  in  1  long op leaves EXE this cycle
lo_issue_rd  in  5  its destination
lo_issue_tag  out  TAG_W  slot allocated (lowest free index)
lo_done  in  1  long op completes writeback
lo_done_tag  in  TAG_W  completing slot
pc_sel_mem  in  1  branch/jump taken in MEM
trap_flush  in  1  trap/mret redirect
stall_pipl  in  1  external stall (bus wait)
pc_reg_en, if_id_reg_en, id_exe_reg_en, exe_mem_reg_en, mem_wb_reg_en  out  1 each
if_id_reg_clr, id_exe_reg_clr, exe_mem_reg_clr, mem_wb_reg_clr  out  1 each
sb_full  out  1  all slots valid
sb_busy_count  out  TAG_W+1  valid slot count
stall_cycles  out  CNT_W  saturating count of cycles with pc_reg_en=0

Behaviour:
- Reset (async, reset_n=0):
  - All slots invalid; stall_cycles=0.
  - While reset_n=0: every *_en=0, every *_clr=1, sb_full=0, sb_busy_count=0.
- Slot table: entry {valid, rd}.
  - lo_issue_tag is combinational: the lowest-index invalid slot, computed from registered state.
  - On posedge with lo_issue=1 and sb_full=0, slot[tag] <= {1, lo_issue_rd}.
  - lo_issue while sb_full=1 is ignored; flag it with an assertion.
- Completion: on posedge with lo_done=1, slot[lo_done_tag].valid <= 0. Done to an invalid slot is ignored (assert).
- Same-cycle issue and done: both take effect. Done of slot k and allocation of a different free slot never conflict.
- Match rule: a slot matches register r when valid && rd==r && r!=0. x0 never hazards.
  - A completing slot still matches in its done cycle. The stall releases the following cycle, giving a fixed 1-cycle penalty with no bypass from lo_done.
- Hazard terms (all qualified by id_valid):
  - raw = (id_use_rs1 && match(id_rs1)) || (id_use_rs2 && match(id_rs2))
  - waw = id_reg_write && match(id_rd)
  - load = exe_mem_read && exe_rd!=0 && ((id_use_rs1 && exe_rd==id_rs1) || (id_use_rs2 && exe_rd==id_rs2))
  - struct = id_long_op && sb_full
  - id_stall = raw | waw | load | struct
- Pipeline control, combinational, strict priority:
  1. trap_flush: all en=1; if_id, id_exe, exe_mem, mem_wb clr=1.
  2. pc_sel_mem: all en=1; if_id, id_exe, exe_mem clr=1; mem_wb clr=0.
  3. stall_pipl: all en=0; all clr=0.
  4. id_stall: pc_reg_en=0, if_id_reg_en=0, id_exe_reg_clr=1 (bubble); other en=1, other clr=0.
  5. Otherwise: all en=1, all clr=0.
- Flushes never clear the scoreboard: ops past EXE are committed and still complete.
- stall_cycles increments on each posedge where pc_reg_en=0 and reset_n=1; it saturates at all-ones.
- sb_full and sb_busy_count are derived from registered valid bits, so they update the cycle after issue/done.

Decomposition:
- Package hazard_pkg: NUM_SLOTS default, slot_t struct {logic valid; logic [4:0] rd;}, pipe_ctrl_t struct of the 9 en/clr bits, and the priority-encoded mode enum {PC_TRAP, PC_BRANCH, PC_EXT_STALL, PC_ID_STALL, PC_RUN}.
- One sub-module, sb_slot_table: owns the slot registers, free-slot priority encoder, popcount and per-register match ports. The top holds hazard logic, the control mux and the counter.

Test Plan:
- Issue rd=5 (tag 0), then ID reads x5 → pc_reg_en=0, id_exe_reg_clr=1 every cycle up to and including the lo_done(tag 0) cycle; run the cycle after; stall_cycles counts exactly those cycles.
- NUM_SLOTS=4: issue 4 long ops → sb_full=1, sb_busy_count=4. ID long op stalls. Done tag 2 then issue → lo_issue_tag=2.
- Load in EXE with exe_rd=7, ID uses rs2=7 → one bubble. Same with exe_rd=0 → no stall.
- id_stall, stall_pipl and pc_sel_mem all high → branch flush pattern (3 clr=1, all en=1). Add trap_flush → mem_wb_reg_clr=1 as well.
- Same-cycle lo_issue and lo_done on different tags with 3 slots busy → busy count stays 3, sb_full stays 0.
- Assert reset_n mid-stall with slots busy → outputs go to reset values immediately. After release, no stall occurs and stall_cycles=0.
